alu_shift_right_seq: RTL

- Sequential right-shift unit; the inverse-direction companion to the ALU's combinational shift-left operation.
- Shifts an nIO-bit operand right one bit per clock, in logical, arithmetic or rotate mode, under a start/busy/done handshake.
- Sits beside the ALU in the datapath, for multi-position right shifts where a full barrel shifter is not wanted.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_shift_right_seq_shr_step.sv | 27 ++
 rtl/alu_shift_right_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential right-shift unit: shift modes and FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        MODE_LSR = 2'b00,
        MODE_ASR = 2'b01,
        MODE_ROR = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // The unused encoding 2'b11 behaves as a logical shift.
    function automatic mode_t decode_mode(input logic [1:0] raw);
        mode_t m;
        case (raw)
            2'b01:   m = MODE_ASR;
            2'b10:   m = MODE_ROR;
            default: m = MODE_LSR;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_shift_right_seq_shr_step.sv
// One-bit right shift of a value by mode; reports the bit that falls off the LSB.
module shr_step
    import alu_pkg::*;
#(
    parameter int nIO = 8
) (
    input  logic [nIO-1:0] value,
    input  mode_t          mode,
    output logic [nIO-1:0] shifted,
    output logic           out_bit
);

    logic fill;

    always_comb begin
        fill = 1'b0;
        case (mode)
            MODE_ASR: fill = value[nIO-1];
            MODE_ROR: fill = value[0];
            default:  fill = 1'b0;
        endcase
    end

    assign shifted = {fill, value[nIO-1:1]};
    assign out_bit = value[0];

endmodule

// File: rtl/alu_shift_right_seq.sv
// Sequential right shifter (logical/arithmetic/rotate) with start/busy/done handshake.
// Define ALU_SHIFT_FAST_EN to shift two bits per cycle while at least two remain.
//
// state | meaning
// IDLE  | waiting for start; Z and OV hold the last result
// SHIFT | shifting Z right, counter holds positions still to go
// DONE  | one-cycle done pulse, then back to IDLE
module alu_shift_right_seq
    import alu_pkg::*;
#(
    parameter int nIO = 8,
    parameter int SHW = $clog2(nIO)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [nIO-1:0] A,
    input  logic [SHW-1:0] SH,
    input  logic [1:0]     MODE,
    output logic           busy,
    output logic           done,
    output logic [nIO-1:0] Z,
    output logic           OV
);

    state_t         state;
    state_t         state_nx;
    logic [SHW-1:0] cnt;
    mode_t          mode_q;
    logic [nIO-1:0] z_q;
    logic           ov_q;

    logic           accept;
    logic           ov_en;
    logic [nIO-1:0] s1_val;
    logic           s1_out;
    logic [nIO-1:0] shift_val;
    logic           shift_ov;
    logic [SHW-1:0] dec;
    logic           last;

    assign accept = (state == IDLE) && start;
    assign ov_en  = (mode_q != MODE_ROR);

    shr_step #(.nIO(nIO)) u_step1 (
        .value   (z_q),
        .mode    (mode_q),
        .shifted (s1_val),
        .out_bit (s1_out)
    );

`ifdef ALU_SHIFT_FAST_EN
    logic [nIO-1:0] s2_val;
    logic           s2_out;
    logic           two;

    shr_step #(.nIO(nIO)) u_step2 (
        .value   (s1_val),
        .mode    (mode_q),
        .shifted (s2_val),
        .out_bit (s2_out)
    );

    assign two       = (cnt >= SHW'(2));
    assign shift_val = two ? s2_val : s1_val;
    assign shift_ov  = s1_out | (two & s2_out);
    assign dec       = two ? SHW'(2) : SHW'(1);
`else
    assign shift_val = s1_val;
    assign shift_ov  = s1_out;
    assign dec       = SHW'(1);
`endif

    // This cycle consumes the remaining count, so the next state is DONE.
    assign last = (cnt <= dec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (SH != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SHIFT: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q    <= '0;
            cnt    <= '0;
            mode_q <= MODE_LSR;
            ov_q   <= 1'b0;
        end else if (accept) begin
            z_q    <= A;
            cnt    <= SH;
            mode_q <= decode_mode(MODE);
            ov_q   <= 1'b0;
        end else if (state == SHIFT) begin
            z_q    <= shift_val;
            cnt    <= cnt - dec;
            ov_q   <= ov_q | (shift_ov & ov_en);
        end
    end

    assign Z  = z_q;
    assign OV = ov_q;

endmodule
